// File: rtl/painterengine_gpu_display_timing.sv
// Raster timing generator: pixel-rate tick, hsync/vsync, data enable, x/y and frame strobes.
// Optional: define PAINTERENGINE_GPU_TIMING_FRAME_COUNT_EN to add the o_wire_frame_count output.
module painterengine_gpu_display_timing #(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned H_FP        = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BP        = 48,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned V_FP        = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BP        = 33,
   parameter int unsigned CLK_DIV     = 2,
   parameter logic        SYNC_ACTIVE = 1'b0
) (
   input  logic        i_wire_clock,
   input  logic        i_wire_reset,
   input  logic        i_wire_enabled,
   output logic        o_wire_hsync,
   output logic        o_wire_vsync,
   output logic        o_wire_de,
   output logic [11:0] o_wire_x,
   output logic [11:0] o_wire_y,
   output logic        o_wire_pixel_tick,
   output logic        o_wire_frame_start
`ifdef PAINTERENGINE_GPU_TIMING_FRAME_COUNT_EN
   ,
   output logic [15:0] o_wire_frame_count
`endif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
   localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
   localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [DIV_W-1:0] div;
   logic [11:0]      hcnt;
   logic [11:0]      vcnt;
   logic [11:0]      hnext;
   logic [11:0]      vnext;
   logic             pixel_edge;
   logic             frame_edge;

   // The first edge out of IDLE loads pixel (0,0) exactly like a regular pixel boundary.
   always_comb begin
      pixel_edge = (state == IDLE) || (div == DIV_LAST);
      hnext      = '0;
      vnext      = '0;
      if (state == RUN) begin
         hnext = (hcnt == H_LAST) ? '0 : hcnt + 12'd1;
         vnext = vcnt;
         if (hcnt == H_LAST) begin
            vnext = (vcnt == V_LAST) ? '0 : vcnt + 12'd1;
         end
      end
      frame_edge = pixel_edge && (hnext == '0) && (vnext == '0);
   end

   always_ff @(posedge i_wire_clock) begin
      if (i_wire_reset || !i_wire_enabled) begin
         state              <= IDLE;
         div                <= '0;
         hcnt               <= '0;
         vcnt               <= '0;
         o_wire_hsync       <= ~SYNC_ACTIVE;
         o_wire_vsync       <= ~SYNC_ACTIVE;
         o_wire_de          <= 1'b0;
         o_wire_pixel_tick  <= 1'b0;
         o_wire_frame_start <= 1'b0;
      end else if (pixel_edge) begin
         state              <= RUN;
         div                <= '0;
         hcnt               <= hnext;
         vcnt               <= vnext;
         o_wire_de          <= (hnext < H_VIS) && (vnext < V_VIS);
         o_wire_hsync       <= (hnext >= HS_START && hnext < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         o_wire_vsync       <= (vnext >= VS_START && vnext < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         o_wire_pixel_tick  <= 1'b1;
         o_wire_frame_start <= frame_edge;
      end else begin
         div                <= div + DIV_W'(1);
         o_wire_pixel_tick  <= 1'b0;
         o_wire_frame_start <= 1'b0;
      end
   end

   assign o_wire_x = hcnt;
   assign o_wire_y = vcnt;

`ifdef PAINTERENGINE_GPU_TIMING_FRAME_COUNT_EN
   // Held across disable; only reset clears it.
   always_ff @(posedge i_wire_clock) begin
      if (i_wire_reset) begin
         o_wire_frame_count <= '0;
      end else if (i_wire_enabled && frame_edge) begin
         o_wire_frame_count <= o_wire_frame_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_painterengine_gpu_display_timing.sv
// Directed bench for painterengine_gpu_display_timing using a reduced raster (15x8 total, CLK_DIV=2 and 1).
module tb_painterengine_gpu_display_timing;

   localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
   localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int unsigned HT = 15, VT = 8, DIV = 2;
   localparam int unsigned FRAME = HT * VT * DIV;
   localparam logic [28:0] IDLE_V = {1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0};

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        hsync, vsync, de, pt, fs;
   logic [11:0] x, y;
   logic        hsync1, vsync1, de1, pt1, fs1;
   logic [11:0] x1, y1;
`ifdef PAINTERENGINE_GPU_TIMING_FRAME_COUNT_EN
   logic [15:0] fc, fc1;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   painterengine_gpu_display_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .CLK_DIV(DIV), .SYNC_ACTIVE(1'b0)
   ) dut (
      .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_enabled(en),
      .o_wire_hsync(hsync), .o_wire_vsync(vsync), .o_wire_de(de),
      .o_wire_x(x), .o_wire_y(y), .o_wire_pixel_tick(pt), .o_wire_frame_start(fs)
`ifdef PAINTERENGINE_GPU_TIMING_FRAME_COUNT_EN
      , .o_wire_frame_count(fc)
`endif
   );

   painterengine_gpu_display_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .CLK_DIV(1), .SYNC_ACTIVE(1'b0)
   ) dut1 (
      .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_enabled(en),
      .o_wire_hsync(hsync1), .o_wire_vsync(vsync1), .o_wire_de(de1),
      .o_wire_x(x1), .o_wire_y(y1), .o_wire_pixel_tick(pt1), .o_wire_frame_start(fs1)
`ifdef PAINTERENGINE_GPU_TIMING_FRAME_COUNT_EN
      , .o_wire_frame_count(fc1)
`endif
   );

   // Expected {hsync,vsync,de,x,y,pixel_tick,frame_start} k clocks after the (0,0) load edge.
   function automatic logic [28:0] model(input int unsigned k, input int unsigned d);
      int unsigned p, ex, ey;
      logic eh, ev, ede, ept, efs;
      p   = k / d;
      ex  = p % HT;
      ey  = (p / HT) % VT;
      eh  = (ex >= HA + HF && ex < HA + HF + HS) ? 1'b0 : 1'b1;
      ev  = (ey >= VA + VF && ey < VA + VF + VS) ? 1'b0 : 1'b1;
      ede = (ex < HA) && (ey < VA);
      ept = (k % d) == 0;
      efs = ept && (ex == 0) && (ey == 0);
      return {eh, ev, ede, 12'(ex), 12'(ey), ept, efs};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) tick();
      checks++;
      if ({hsync, vsync, de, x, y, pt, fs} !== IDLE_V) begin
         failures++;
         $display("FAIL reset_values got=%h want=%h", {hsync, vsync, de, x, y, pt, fs}, IDLE_V);
      end
      rst = 1'b0;
      for (int unsigned i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({hsync, vsync, de, x, y, pt, fs} !== IDLE_V || {hsync1, vsync1, de1, pt1} !== 4'b1100) begin
            failures++;
            $display("FAIL idle_hold cyc=%0d got=%h want=%h", i, {hsync, vsync, de, x, y, pt, fs}, IDLE_V);
         end
      end
`ifdef PAINTERENGINE_GPU_TIMING_FRAME_COUNT_EN
      checks++;
      if (fc !== 16'd0) begin
         failures++;
         $display("FAIL frame_count_reset got=%0d want=0", fc);
      end
`endif
   endtask

   task automatic test_start();
      en = 1'b1;
      tick();
      checks++;
      if ({de, x, y, pt, fs} !== {1'b1, 12'd0, 12'd0, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL start_pixel got de=%b x=%0d y=%0d pt=%b fs=%b want 1,0,0,1,1", de, x, y, pt, fs);
      end
      tick();
      checks++;
      if ({x, pt, fs} !== {12'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL second_clock got x=%0d pt=%b fs=%b want 0,0,0", x, pt, fs);
      end
      tick();
      checks++;
      if ({x, pt, fs} !== {12'd1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL x1_after_2 got x=%0d pt=%b fs=%b want 1,1,0", x, pt, fs);
      end
   endtask

   // Continues from k=2; runs through the wrap into the second frame (k=FRAME).
   task automatic test_frame();
      int unsigned hs_low = 0, vs_low = 0, fs_seen = 0;
      logic [28:0] exp, exp1;
      for (int unsigned k = 3; k <= FRAME; k++) begin
         tick();
         exp  = model(k, DIV);
         exp1 = model(k, 1);
         checks++;
         if ({hsync, vsync, de, x, y, pt, fs} !== exp) begin
            failures++;
            $display("FAIL raster k=%0d got=%h want=%h", k, {hsync, vsync, de, x, y, pt, fs}, exp);
         end
         checks++;
         if ({hsync1, vsync1, de1, x1, y1, pt1, fs1} !== exp1) begin
            failures++;
            $display("FAIL raster_div1 k=%0d got=%h want=%h", k, {hsync1, vsync1, de1, x1, y1, pt1, fs1}, exp1);
         end
         if (k < HT * DIV && hsync == 1'b0) hs_low++;
         if (k < FRAME && vsync == 1'b0) vs_low++;
         if (k < FRAME && fs == 1'b1) fs_seen++;
         if (k == 16) begin
            checks++;
            if ({de, x} !== {1'b0, 12'd8}) begin
               failures++;
               $display("FAIL de_fall got de=%b x=%0d want 0,8", de, x);
            end
         end
         if (k == HT * DIV) begin
            checks++;
            if ({x, y} !== {12'd0, 12'd1}) begin
               failures++;
               $display("FAIL line_wrap got x=%0d y=%0d want 0,1", x, y);
            end
         end
      end
      checks++;
      if (hs_low != 6) begin
         failures++;
         $display("FAIL hsync_width got=%0d want=6", hs_low);
      end
      checks++;
      if (vs_low != 60) begin
         failures++;
         $display("FAIL vsync_width got=%0d want=60", vs_low);
      end
      checks++;
      if (fs_seen != 0 || {x, y, fs} !== {12'd0, 12'd0, 1'b1}) begin
         failures++;
         $display("FAIL frame_wrap mid_fs=%0d x=%0d y=%0d fs=%b want 0,0,0,1", fs_seen, x, y, fs);
      end
`ifdef PAINTERENGINE_GPU_TIMING_FRAME_COUNT_EN
      checks++;
      if (fc !== 16'd2) begin
         failures++;
         $display("FAIL frame_count got=%0d want=2", fc);
      end
`endif
   endtask

   // Starts at k=FRAME (pixel (0,0) of frame 2); pixel (3,2) begins 66 clocks later.
   task automatic test_disable();
      repeat (66) tick();
      checks++;
      if ({x, y} !== {12'd3, 12'd2}) begin
         failures++;
         $display("FAIL pre_disable got x=%0d y=%0d want 3,2", x, y);
      end
      en = 1'b0;
      tick();
      checks++;
      if ({hsync, vsync, de, x, y, pt, fs} !== IDLE_V) begin
         failures++;
         $display("FAIL disable got=%h want=%h", {hsync, vsync, de, x, y, pt, fs}, IDLE_V);
      end
      repeat (4) tick();
      checks++;
      if ({hsync, vsync, de, x, y, pt, fs} !== IDLE_V) begin
         failures++;
         $display("FAIL disable_hold got=%h want=%h", {hsync, vsync, de, x, y, pt, fs}, IDLE_V);
      end
`ifdef PAINTERENGINE_GPU_TIMING_FRAME_COUNT_EN
      checks++;
      if (fc !== 16'd2) begin
         failures++;
         $display("FAIL frame_count_held got=%0d want=2", fc);
      end
`endif
      en = 1'b1;
      tick();
      checks++;
      if ({hsync, vsync, de, x, y, pt, fs} !== model(0, DIV)) begin
         failures++;
         $display("FAIL reenable got=%h want=%h", {hsync, vsync, de, x, y, pt, fs}, model(0, DIV));
      end
`ifdef PAINTERENGINE_GPU_TIMING_FRAME_COUNT_EN
      checks++;
      if (fc !== 16'd3) begin
         failures++;
         $display("FAIL frame_count_reenable got=%0d want=3", fc);
      end
`endif
   endtask

   task automatic test_reset_while_enabled();
      repeat (5) tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({hsync, vsync, de, x, y, pt, fs} !== IDLE_V) begin
         failures++;
         $display("FAIL reset_priority got=%h want=%h", {hsync, vsync, de, x, y, pt, fs}, IDLE_V);
      end
      tick();
      checks++;
      if ({hsync1, vsync1, de1, x1, y1, pt1, fs1} !== IDLE_V) begin
         failures++;
         $display("FAIL reset_priority_div1 got=%h want=%h", {hsync1, vsync1, de1, x1, y1, pt1, fs1}, IDLE_V);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({hsync, vsync, de, x, y, pt, fs} !== model(0, DIV)) begin
         failures++;
         $display("FAIL restart_after_reset got=%h want=%h", {hsync, vsync, de, x, y, pt, fs}, model(0, DIV));
      end
`ifdef PAINTERENGINE_GPU_TIMING_FRAME_COUNT_EN
      checks++;
      if (fc !== 16'd1) begin
         failures++;
         $display("FAIL frame_count_after_reset got=%0d want=1", fc);
      end
`endif
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      test_reset();
      test_start();
      test_frame();
      test_disable();
      test_reset_while_enabled();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
